// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready byte output, framing-error and overrun pulses.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity check, o_parity_err).
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned clk_freq_hz = 27000000,
  parameter int unsigned baud_rate   = 9600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int unsigned BIT_CYCLES  = clk_freq_hz / baud_rate;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CNT_W       = $clog2(BIT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_idx_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             w_rx_s;
  logic             w_expired;
  logic             w_deliver;
  logic             w_frame_err;
`ifdef UART_RX_PARITY_EN
  logic             r_par_err;
  logic             w_par_next;
`endif

  assign w_rx_s    = r_sync2;
  assign w_expired = (r_cnt == '0);

  // Two-flop synchronizer for the asynchronous line; idles high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_idx_next;
      r_shift   <= w_shift_next;
`ifdef UART_RX_PARITY_EN
      r_par_err <= w_par_next;
`endif
    end
  end

  // Next state: every sample is taken when the down-counter expires mid-bit
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_deliver    = 1'b0;
    w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_next   = r_par_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_cnt_next   = CNT_W'(HALF_CYCLES - 1);
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_expired) begin
          if (!w_rx_s) begin
            w_cnt_next   = CNT_W'(BIT_CYCLES - 1);
            w_idx_next   = 3'd0;
            w_state_next = S_DATA;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_expired) begin
          w_shift_next = {w_rx_s, r_shift[7:1]};
          w_cnt_next   = CNT_W'(BIT_CYCLES - 1);
          w_idx_next   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_expired) begin
          w_par_next   = w_rx_s ^ (^r_shift);
          w_cnt_next   = CNT_W'(BIT_CYCLES - 1);
          w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_expired) begin
          if (w_rx_s) begin
            w_deliver    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = S_BREAK;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (w_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output register: a byte is dropped (overrun) if the previous one is still held
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err  <= w_frame_err;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      if (w_deliver) begin
        if (!o_valid || i_ready) begin
          o_data       <= r_shift;
          o_valid      <= 1'b1;
`ifdef UART_RX_PARITY_EN
          o_parity_err <= r_par_err;
`endif
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 MHz / 100 kbaud (10 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned BIT = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam int LAT   = 108;
`else
  localparam int NBITS = 10;
  localparam int LAT   = 98;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_uart_rx = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_parity_err;

  uart_rx #(.clk_freq_hz(1000000), .baud_rate(100000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_uart_rx(i_uart_rx),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_parity_err(o_parity_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: observed events, sampled on the falling edge
  logic [7:0] acc_q[$];
  int m_ferr, m_ovr, m_perr, m_nrise, m_vcyc, m_vrise_cyc, m_perr_cyc, m_start;
  logic       p_valid = 1'b0;
  logic       p_acc   = 1'b0;
  logic       p_rst   = 1'b1;
  logic [7:0] p_data  = 8'h00;

  always @(negedge i_clk) begin
    if (o_frame_err) m_ferr++;
    if (o_overrun) m_ovr++;
    if (o_parity_err) begin m_perr++; m_perr_cyc = cyc; end
    if (o_valid) m_vcyc++;
    if (o_valid && !p_valid) begin m_nrise++; m_vrise_cyc = cyc; end
    if (p_valid && !p_acc && !p_rst) begin
      n_tests++;
      if (o_valid !== 1'b1 || o_data !== p_data) begin
        n_fail++;
        $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", o_valid, o_data, p_data);
      end
    end
    if (o_valid && i_ready) acc_q.push_back(o_data);
    p_valid = o_valid;
    p_acc   = o_valid && i_ready;
    p_rst   = i_rst;
    p_data  = o_data;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_mon();
    acc_q.delete();
    m_ferr = 0; m_ovr = 0; m_perr = 0; m_nrise = 0; m_vcyc = 0;
    m_vrise_cyc = 0; m_perr_cyc = -1;
  endtask

  // Drive one frame; rst_bit >= 0 pulses i_rst for one cycle at the start of that bit
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                            input int rst_bit);
    logic [10:0] fr;
    logic [3:0]  bi;
`ifdef UART_RX_PARITY_EN
    fr = {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
    fr = {1'b0, stop_b, d, 1'b0};
    if (par_flip) fr[10] = 1'b0;
`endif
    m_start = cyc;
    for (int b = 0; b < NBITS; b++) begin
      bi = 4'(b);
      i_uart_rx = fr[bi];
      if (b == rst_bit) i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      repeat (BIT - 1) tick();
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (o_valid !== 1'b0 || o_data !== 8'h00 || o_frame_err !== 1'b0 ||
        o_overrun !== 1'b0 || o_parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: valid=%b data=%h ferr=%b ovr=%b perr=%b, required all 0",
               o_valid, o_data, o_frame_err, o_overrun, o_parity_err);
    end
    i_rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    repeat (5) tick();
    n_tests++;
    if (acc_q.size() != 1 || acc_q[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_data: got %0d bytes first=%h, required 1 byte a5", acc_q.size(),
               (acc_q.size() > 0) ? acc_q[0] : 8'h00);
    end
    n_tests++;
    if (m_vrise_cyc - m_start < LAT - 1 || m_vrise_cyc - m_start > LAT + 1) begin
      n_fail++;
      $display("FAIL basic_latency: %0d cycles, required %0d +-1", m_vrise_cyc - m_start, LAT);
    end
    n_tests++;
    if (m_vcyc != 1 || m_ferr != 0 || m_ovr != 0 || m_perr != 0) begin
      n_fail++;
      $display("FAIL basic_pulses: valid_cycles=%0d ferr=%0d ovr=%0d perr=%0d, required 1/0/0/0",
               m_vcyc, m_ferr, m_ovr, m_perr);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    i_uart_rx = 1'b0;
    repeat (3) tick();
    i_uart_rx = 1'b1;
    repeat (30) tick();
    n_tests++;
    if (m_nrise != 0 || m_ferr != 0 || m_ovr != 0 || m_perr != 0) begin
      n_fail++;
      $display("FAIL glitch: valids=%0d ferr=%0d ovr=%0d perr=%0d, required all 0",
               m_nrise, m_ferr, m_ovr, m_perr);
    end
    send_frame(8'h5C, 1'b1, 1'b0, -1);
    repeat (5) tick();
    n_tests++;
    if (acc_q.size() != 1 || acc_q[0] !== 8'h5C) begin
      n_fail++;
      $display("FAIL glitch_recover: got %0d bytes, required 1 byte 5c", acc_q.size());
    end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    repeat (50) tick();
    n_tests++;
    if (m_ferr != 1 || m_nrise != 0 || m_ovr != 0 || m_perr != 0) begin
      n_fail++;
      $display("FAIL frame_err: ferr_cycles=%0d valids=%0d ovr=%0d perr=%0d, required 1/0/0/0",
               m_ferr, m_nrise, m_ovr, m_perr);
    end
    i_uart_rx = 1'b1;
    repeat (5) tick();
    send_frame(8'h81, 1'b1, 1'b0, -1);
    repeat (5) tick();
    n_tests++;
    if (acc_q.size() != 1 || acc_q[0] !== 8'h81 || m_ferr != 1) begin
      n_fail++;
      $display("FAIL frame_err_recover: bytes=%0d ferr=%0d, required 1 byte 81, ferr 1",
               acc_q.size(), m_ferr);
    end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    repeat (5) tick();
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 8'h11 || m_ovr != 1 || m_ferr != 0) begin
      n_fail++;
      $display("FAIL overrun: valid=%b data=%h ovr=%0d ferr=%0d, required 1/11/1/0",
               o_valid, o_data, m_ovr, m_ferr);
    end
    i_ready = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (o_valid !== 1'b0 || acc_q.size() != 1 || acc_q[0] !== 8'h11) begin
      n_fail++;
      $display("FAIL overrun_drain: valid=%b bytes=%0d, required valid 0, 1 byte 11",
               o_valid, acc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    clear_mon();
    send_frame(8'h33, 1'b1, 1'b0, -1);
    repeat (3) tick();
    send_frame(8'hFF, 1'b1, 1'b0, 4);
    repeat (20) tick();
    n_tests++;
    if (o_valid !== 1'b0 || m_ferr != 0 || m_ovr != 0 || m_perr != 0 || m_nrise != 1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b ferr=%0d ovr=%0d perr=%0d rises=%0d, required 0/0/0/0/1",
               o_valid, m_ferr, m_ovr, m_perr, m_nrise);
    end
    i_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    repeat (5) tick();
    n_tests++;
    if (acc_q.size() != 1 || acc_q[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL reset_mid_recover: bytes=%0d, required 1 byte 5a", acc_q.size());
    end
  endtask

  // Random bytes, random bad stop bits (and parity flips), random idle gaps
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       bad;
    logic       pf;
    int         exp_ferr;
    int         exp_perr;
    exp_ferr = 0;
    exp_perr = 0;
    i_ready = 1'b1;
    clear_mon();
    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_PARITY_EN
      pf  = 1'($urandom_range(0, 1));
`else
      pf  = 1'b0;
`endif
      if (bad) exp_ferr++;
      else begin
        exp_q.push_back(d);
        if (pf) exp_perr++;
      end
      send_frame(d, !bad, pf, -1);
      i_uart_rx = 1'b1;
      repeat ($urandom_range(2, 15)) tick();
    end
    repeat (5) tick();
    n_tests++;
    if (acc_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: %0d bytes, required %0d", acc_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_tests++;
        if (acc_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_byte%0d: %h, required %h", i, acc_q[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (m_ferr != exp_ferr || m_perr != exp_perr || m_ovr != 0) begin
      n_fail++;
      $display("FAIL random_errs: ferr=%0d perr=%0d ovr=%0d, required %0d/%0d/0",
               m_ferr, m_perr, m_ovr, exp_ferr, exp_perr);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    i_ready = 1'b1;
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, -1);
    repeat (5) tick();
    n_tests++;
    if (acc_q.size() != 1 || acc_q[0] !== 8'h07 || m_perr != 1 || m_perr_cyc != m_vrise_cyc) begin
      n_fail++;
      $display("FAIL parity_bad: bytes=%0d perr=%0d perr_cyc=%0d valid_cyc=%0d, required 1 byte 07, 1 pulse with valid",
               acc_q.size(), m_perr, m_perr_cyc, m_vrise_cyc);
    end
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, -1);
    repeat (5) tick();
    n_tests++;
    if (acc_q.size() != 1 || acc_q[0] !== 8'h07 || m_perr != 0) begin
      n_fail++;
      $display("FAIL parity_good: bytes=%0d perr=%0d, required 1 byte 07, 0 pulses",
               acc_q.size(), m_perr);
    end
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
